traffic_lane_gen: RTL and testbench

// - Multi-lane random traffic source and queue model for the traffic light simulator.
// - Each lane has its own LFSR. Each enabled cycle, a lane draws a random car arrival

---
 rtl/traffic_pkg.sv | 48 ++++
 rtl/lane_lfsr.sv | 35 +++
 rtl/traffic_lane_gen.sv | 105 ++++++++++
 tb/tb_traffic_lane_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared tap table, seed and width helpers for the traffic lane generator
package traffic_pkg;

    localparam logic [7:0] DEFAULT_SEED = 8'hA5;
    localparam logic [7:0] SEED_STEP    = 8'h3B;

    // Maximal-length feedback mask for a right-shifting Fibonacci LFSR.
    // Bit j set means state bit j feeds the new MSB; bit 0 is always set so
    // the characteristic polynomial has a constant term.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            5:       taps = 16'h0009;
            6:       taps = 16'h0021;
            7:       taps = 16'h0041;
            8:       taps = 16'h0071;
            9:       taps = 16'h0021;
            10:      taps = 16'h0081;
            11:      taps = 16'h0201;
            12:      taps = 16'h0053;
            13:      taps = 16'h001B;
            14:      taps = 16'h002B;
            15:      taps = 16'h4001;
            16:      taps = 16'hA011;
            default: taps = 16'h0071;
        endcase
        return taps;
    endfunction

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Per-lane seed: base ^ (lane * step), trimmed to the LFSR width; zero is illegal.
    function automatic logic [15:0] lane_seed(input int lane, input logic [7:0] base, input int width);
        logic [31:0] s;
        s = {24'd0, base} ^ (32'(lane) * {24'd0, SEED_STEP});
        s = s & ((32'd1 << width) - 32'd1);
        if (s == 32'd0) begin
            s = 32'd1;
        end
        return s[15:0];
    endfunction

endpackage

// File: rtl/lane_lfsr.sv
// rtl/lane_lfsr.sv - per-lane Fibonacci LFSR that advances on demand
module lane_lfsr
    import traffic_pkg::*;
#(
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] SEED   = {{(LFSR_W-1){1'b0}}, 1'b1}
) (
    input  logic              traffic_clk,
    input  logic              reset_n,
    input  logic              advance,
    output logic [LFSR_W-1:0] rand_q
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    logic [LFSR_W-1:0] lfsr_d;

    // Shift right, feed the XOR of the tapped bits into the MSB; hold when not advancing.
    always_comb begin
        lfsr_d = rand_q;
        if (advance) begin
            lfsr_d = {^(rand_q & TAPS), rand_q[LFSR_W-1:1]};
        end
    end

    // State register; a nonzero seed keeps the sequence off the all-zero lockup state.
    always_ff @(posedge traffic_clk or negedge reset_n) begin
        if (!reset_n) begin
            rand_q <= SEED;
        end else begin
            rand_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/traffic_lane_gen.sv
// rtl/traffic_lane_gen.sv - multi-lane random car arrival source with per-lane queue and headway
module traffic_lane_gen
    import traffic_pkg::*;
#(
    parameter int         NUM_LANES   = 2,
    parameter int         LFSR_W      = 8,
    parameter int         LEVEL_W     = 5,
    parameter int         QUEUE_DEPTH = 15,
    parameter int         DEPART_GAP  = 2,
    parameter logic [7:0] SEED_BASE   = DEFAULT_SEED,
    localparam int        CNT_W       = cnt_width(QUEUE_DEPTH)
) (
    input  logic                         traffic_clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [NUM_LANES-1:0]         lane_green,
    input  logic [NUM_LANES*LEVEL_W-1:0] traffic_lvl,
    output logic [NUM_LANES-1:0]         add_car,
    output logic [NUM_LANES*CNT_W-1:0]   queue_count,
    output logic [NUM_LANES-1:0]         car_waiting,
    output logic [NUM_LANES-1:0]         queue_full,
    output logic [NUM_LANES-1:0]         car_dropped
);

    localparam int             GAP_W = cnt_width(DEPART_GAP);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(QUEUE_DEPTH);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [LFSR_W-1:0] LANE_SEED = LFSR_W'(lane_seed(i, SEED_BASE, LFSR_W));

        logic [LFSR_W-1:0] lfsr_state;
        logic [LFSR_W-1:0] rand_ext;
        logic [LFSR_W-1:0] lvl_ext;
        logic              arrive;
        logic              depart;
        logic [CNT_W-1:0]  count_q, count_d;
        logic [GAP_W-1:0]  headway_q, headway_d;
        logic              add_q, add_d;
        logic              drop_q, drop_d;

        lane_lfsr #(
            .LFSR_W (LFSR_W),
            .SEED   (LANE_SEED)
        ) u_lfsr (
            .traffic_clk (traffic_clk),
            .reset_n     (reset_n),
            .advance     (enable),
            .rand_q      (lfsr_state)
        );

        // The random draw is the top LEVEL_W bits of the pre-shift state.
        assign rand_ext = lfsr_state >> (LFSR_W - LEVEL_W);
        assign lvl_ext  = LFSR_W'(traffic_lvl[i*LEVEL_W +: LEVEL_W]);
        assign arrive   = enable && (lvl_ext > rand_ext);
        assign depart   = lane_green[i] && (count_q != '0) && (headway_q == '0);

        // Queue, headway and pulse next-state; a simultaneous arrival and departure cancel out.
        always_comb begin
            count_d   = count_q;
            headway_d = headway_q;
            add_d     = 1'b0;
            drop_d    = 1'b0;
            if (depart) begin
                add_d     = 1'b1;
                headway_d = GAP_W'(DEPART_GAP);
                if (!arrive) begin
                    count_d = count_q - CNT_W'(1);
                end
            end else begin
                if (headway_q != '0) begin
                    headway_d = headway_q - GAP_W'(1);
                end
                if (arrive) begin
                    if (count_q == FULL) begin
                        drop_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
        end

        // Lane state registers; reset discards any pulse in flight.
        always_ff @(posedge traffic_clk or negedge reset_n) begin
            if (!reset_n) begin
                count_q   <= '0;
                headway_q <= '0;
                add_q     <= 1'b0;
                drop_q    <= 1'b0;
            end else begin
                count_q   <= count_d;
                headway_q <= headway_d;
                add_q     <= add_d;
                drop_q    <= drop_d;
            end
        end

        assign add_car[i]                    = add_q;
        assign car_dropped[i]                = drop_q;
        assign queue_count[i*CNT_W +: CNT_W] = count_q;
        assign car_waiting[i]                = (count_q != '0);
        assign queue_full[i]                 = (count_q == FULL);
    end

endmodule

// File: tb/tb_traffic_lane_gen.sv
// tb/tb_traffic_lane_gen.sv - directed self-checking bench for traffic_lane_gen
module tb_traffic_lane_gen;

    logic       traffic_clk = 1'b0;
    logic       reset_n     = 1'b0;
    logic       enable      = 1'b0;
    logic [1:0] lane_green  = 2'b00;
    logic [9:0] traffic_lvl = 10'd0;
    logic [1:0] add_car;
    logic [7:0] queue_count;
    logic [1:0] car_waiting;
    logic [1:0] queue_full;
    logic [1:0] car_dropped;

    logic        sweep_adv = 1'b0;
    logic [4:0]  st5;
    logic [7:0]  st8;
    logic [15:0] st16;

    logic [7:0]  m_lfsr0;

    int checks   = 0;
    int failures = 0;

    always #5 traffic_clk = ~traffic_clk;

    traffic_lane_gen dut (
        .traffic_clk (traffic_clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .lane_green  (lane_green),
        .traffic_lvl (traffic_lvl),
        .add_car     (add_car),
        .queue_count (queue_count),
        .car_waiting (car_waiting),
        .queue_full  (queue_full),
        .car_dropped (car_dropped)
    );

    lane_lfsr #(.LFSR_W(5),  .SEED(5'h05))    u_l5  (.traffic_clk(traffic_clk), .reset_n(reset_n), .advance(sweep_adv), .rand_q(st5));
    lane_lfsr #(.LFSR_W(8),  .SEED(8'hA5))    u_l8  (.traffic_clk(traffic_clk), .reset_n(reset_n), .advance(sweep_adv), .rand_q(st8));
    lane_lfsr #(.LFSR_W(16), .SEED(16'h00A5)) u_l16 (.traffic_clk(traffic_clk), .reset_n(reset_n), .advance(sweep_adv), .rand_q(st16));

    // Reference for lane 0 draws: x^8+x^6+x^5+x^4+1, state bit 0 oldest.
    always @(posedge traffic_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_lfsr0 <= 8'hA5;
        end else if (enable) begin
            m_lfsr0 <= {m_lfsr0[0] ^ m_lfsr0[4] ^ m_lfsr0[5] ^ m_lfsr0[6], m_lfsr0[7:1]};
        end
    end

    task automatic test_reset;
        reset_n     = 1'b0;
        enable      = 1'b0;
        lane_green  = 2'b00;
        traffic_lvl = 10'd0;
        repeat (2) @(posedge traffic_clk);
        #1;
        checks++; if (queue_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%h exp=00", queue_count); end
        checks++; if (add_car !== 2'b00) begin failures++; $display("FAIL reset_add_car got=%b exp=00", add_car); end
        checks++; if (car_dropped !== 2'b00) begin failures++; $display("FAIL reset_dropped got=%b exp=00", car_dropped); end
        checks++; if (car_waiting !== 2'b00 || queue_full !== 2'b00) begin failures++; $display("FAIL reset_flags waiting=%b full=%b exp=00/00", car_waiting, queue_full); end
        @(negedge traffic_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_level_zero;
        int bad_cnt = 0;
        int bad_add = 0;
        int bad_drop = 0;
        @(negedge traffic_clk);
        traffic_lvl = 10'd0;
        lane_green  = 2'b11;
        enable      = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge traffic_clk);
            #1;
            if (queue_count != 8'd0) bad_cnt++;
            if (add_car != 2'b00) bad_add++;
            if (car_dropped != 2'b00) bad_drop++;
        end
        checks++; if (bad_cnt !== 0) begin failures++; $display("FAIL lvl0_count nonzero_cycles=%0d exp=0", bad_cnt); end
        checks++; if (bad_add !== 0) begin failures++; $display("FAIL lvl0_add_car pulses=%0d exp=0", bad_add); end
        checks++; if (bad_drop !== 0) begin failures++; $display("FAIL lvl0_dropped pulses=%0d exp=0", bad_drop); end
        @(negedge traffic_clk);
        lane_green = 2'b00;
    endtask

    task automatic test_saturate;
        int prev = 0;
        int cnt;
        int decs = 0;
        int drops = 0;
        int bad_drop = 0;
        @(negedge traffic_clk);
        traffic_lvl = {5'd0, 5'd31};
        lane_green  = 2'b00;
        enable      = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge traffic_clk);
            #1;
            cnt = int'(queue_count[3:0]);
            if (cnt < prev) decs++;
            if (car_dropped[0]) begin
                drops++;
                if (prev != 15) bad_drop++;
            end
            prev = cnt;
        end
        checks++; if (decs !== 0) begin failures++; $display("FAIL sat_no_wrap decreases=%0d exp=0", decs); end
        checks++; if (queue_count[3:0] !== 4'd15) begin failures++; $display("FAIL sat_count got=%0d exp=15", queue_count[3:0]); end
        checks++; if (queue_full[0] !== 1'b1 || car_waiting[0] !== 1'b1) begin failures++; $display("FAIL sat_flags full=%b waiting=%b exp=1/1", queue_full[0], car_waiting[0]); end
        checks++; if (drops == 0) begin failures++; $display("FAIL sat_drop_seen got=%0d exp>0", drops); end
        checks++; if (bad_drop !== 0) begin failures++; $display("FAIL sat_drop_early got=%0d exp=0", bad_drop); end
        checks++; if (queue_count[7:4] !== 4'd0) begin failures++; $display("FAIL sat_lane1_idle got=%0d exp=0", queue_count[7:4]); end
        @(negedge traffic_clk);
        enable = 1'b0;
    endtask

    task automatic test_drain_headway;
        int last = -1;
        int first = -1;
        int pulses = 0;
        int bad_gap = 0;
        int grew = 0;
        @(negedge traffic_clk);
        traffic_lvl = {5'd0, 5'd31};
        enable      = 1'b0;
        lane_green  = 2'b01;
        for (int c = 0; c < 50; c++) begin
            @(posedge traffic_clk);
            #1;
            if (add_car[0]) begin
                if (last >= 0 && (c - last) != 3) bad_gap++;
                if (first < 0) first = c;
                last = c;
                pulses++;
            end
            if (car_dropped[0]) grew++;
        end
        checks++; if (pulses !== 15) begin failures++; $display("FAIL drain_pulses got=%0d exp=15", pulses); end
        checks++; if (bad_gap !== 0) begin failures++; $display("FAIL drain_gap bad=%0d exp=0", bad_gap); end
        checks++; if (first !== 0) begin failures++; $display("FAIL drain_first_edge got=%0d exp=0", first); end
        checks++; if (queue_count[3:0] !== 4'd0 || car_waiting[0] !== 1'b0) begin failures++; $display("FAIL drain_empty count=%0d waiting=%b exp=0/0", queue_count[3:0], car_waiting[0]); end
        checks++; if (grew !== 0) begin failures++; $display("FAIL drain_enable_off drops=%0d exp=0", grew); end
        checks++; if (add_car[1] !== 1'b0) begin failures++; $display("FAIL drain_lane1 add_car=%b exp=0", add_car[1]); end
        @(negedge traffic_clk);
        lane_green = 2'b00;
    endtask

    task automatic test_full_depart_arrive;
        int    filled = 0;
        int    ecnt = 15;
        int    ehw = 0;
        logic  arr, dep, eadd, edrop;
        int    both = 0;
        int    bad = 0;
        @(negedge traffic_clk);
        traffic_lvl = {5'd0, 5'd31};
        lane_green  = 2'b00;
        enable      = 1'b1;
        for (int c = 0; c < 60 && filled == 0; c++) begin
            @(posedge traffic_clk);
            #1;
            if (queue_count[3:0] == 4'd15) filled = 1;
        end
        checks++; if (filled !== 1) begin failures++; $display("FAIL full_fill got=%0d exp=15 within 60 cycles", queue_count[3:0]); end
        for (int c = 0; c < 30; c++) begin
            @(negedge traffic_clk);
            lane_green = 2'b01;
            arr   = (5'd31 > m_lfsr0[7:3]);
            dep   = (ecnt != 0) && (ehw == 0);
            eadd  = dep;
            edrop = 1'b0;
            if (dep) begin
                ehw = 2;
                if (!arr) ecnt--;
                if (arr && ecnt == 15) both++;
            end else begin
                if (ehw != 0) ehw--;
                if (arr) begin
                    if (ecnt == 15) edrop = 1'b1;
                    else ecnt++;
                end
            end
            @(posedge traffic_clk);
            #1;
            if (add_car[0] !== eadd || car_dropped[0] !== edrop || int'(queue_count[3:0]) != ecnt) begin
                bad++;
                if (bad <= 3) $display("FAIL full_step c=%0d add=%b/%b drop=%b/%b count=%0d/%0d (got/exp)",
                                       c, add_car[0], eadd, car_dropped[0], edrop, queue_count[3:0], ecnt);
            end
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL full_steps bad=%0d exp=0", bad); end
        checks++; if (both == 0) begin failures++; $display("FAIL full_both_events got=%0d exp>0", both); end
        @(negedge traffic_clk);
        lane_green = 2'b00;
        enable     = 1'b0;
    endtask

    task automatic test_async_reset;
        @(negedge traffic_clk);
        traffic_lvl = {5'd31, 5'd31};
        lane_green  = 2'b01;
        enable      = 1'b1;
        repeat (10) @(posedge traffic_clk);
        #1;
        checks++; if (queue_count[7:4] == 4'd0) begin failures++; $display("FAIL arst_pre_lane1 got=%0d exp>0", queue_count[7:4]); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (queue_count !== 8'd0) begin failures++; $display("FAIL arst_count got=%h exp=00", queue_count); end
        checks++; if (add_car !== 2'b00 || car_dropped !== 2'b00) begin failures++; $display("FAIL arst_pulses add=%b drop=%b exp=00/00", add_car, car_dropped); end
        checks++; if (car_waiting !== 2'b00 || queue_full !== 2'b00) begin failures++; $display("FAIL arst_flags waiting=%b full=%b exp=00/00", car_waiting, queue_full); end
        checks++; if (dut.g_lane[0].u_lfsr.rand_q !== 8'hA5) begin failures++; $display("FAIL arst_seed0 got=%h exp=a5", dut.g_lane[0].u_lfsr.rand_q); end
        checks++; if (dut.g_lane[1].u_lfsr.rand_q !== 8'h9E) begin failures++; $display("FAIL arst_seed1 got=%h exp=9e", dut.g_lane[1].u_lfsr.rand_q); end
        enable      = 1'b0;
        lane_green  = 2'b00;
        traffic_lvl = 10'd0;
        @(negedge traffic_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_lfsr_sweep;
        int z5 = 0, z8 = 0, z16 = 0;
        int e5 = 0, e8 = 0, e16 = 0;
        sweep_adv = 1'b0;
        repeat (5) @(posedge traffic_clk);
        #1;
        checks++; if (st5 !== 5'h05 || st8 !== 8'hA5 || st16 !== 16'h00A5) begin failures++; $display("FAIL sweep_frozen got=%h/%h/%h exp=05/a5/00a5", st5, st8, st16); end
        @(negedge traffic_clk);
        sweep_adv = 1'b1;
        for (int k = 1; k <= 65535; k++) begin
            @(posedge traffic_clk);
            #1;
            if (st5 == 5'd0) z5++;
            if (st8 == 8'd0) z8++;
            if (st16 == 16'd0) z16++;
            if (k < 31 && st5 == 5'h05) e5++;
            if (k < 255 && st8 == 8'hA5) e8++;
            if (k < 65535 && st16 == 16'h00A5) e16++;
            if (k == 31) begin
                checks++; if (st5 !== 5'h05) begin failures++; $display("FAIL sweep_period5 got=%h exp=05", st5); end
            end
            if (k == 255) begin
                checks++; if (st8 !== 8'hA5) begin failures++; $display("FAIL sweep_period8 got=%h exp=a5", st8); end
            end
            if (k == 65535) begin
                checks++; if (st16 !== 16'h00A5) begin failures++; $display("FAIL sweep_period16 got=%h exp=00a5", st16); end
            end
        end
        checks++; if (z5 + z8 + z16 !== 0) begin failures++; $display("FAIL sweep_zero got=%0d/%0d/%0d exp=0/0/0", z5, z8, z16); end
        checks++; if (e5 + e8 + e16 !== 0) begin failures++; $display("FAIL sweep_short_cycle got=%0d/%0d/%0d exp=0/0/0", e5, e8, e16); end
        @(negedge traffic_clk);
        sweep_adv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_level_zero();
        test_saturate();
        test_drain_headway();
        test_full_depart_arrive();
        test_async_reset();
        test_reset();
        test_lfsr_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
